// File: rtl/frodo_pkg.sv
// Shared FrodoKEM datapath definitions: security-level encodings,
// matrix dimensions and the sample-feeder state type.
package frodo_pkg;

    localparam logic [2:0] CTRL_640  = 3'b001;
    localparam logic [2:0] CTRL_976  = 3'b010;
    localparam logic [2:0] CTRL_1344 = 3'b100;

    localparam int N_640  = 640;
    localparam int N_976  = 976;
    localparam int N_1344 = 1344;
    localparam int NBAR   = 8;

    localparam int NS_640  = N_640 * NBAR;
    localparam int NS_976  = N_976 * NBAR;
    localparam int NS_1344 = N_1344 * NBAR;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_DONE
    } feeder_state_t;

    // Strings per run for a one-hot level; zero for an illegal code.
    function automatic int ns_for(input logic [2:0] c, input int nbar);
        case (c)
            CTRL_640:  return N_640 * nbar;
            CTRL_976:  return N_976 * nbar;
            CTRL_1344: return N_1344 * nbar;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/sample_feeder.sv
// Gaussian sampler feeder: takes 64-bit expander words and hands the
// sampler one 16-bit string per cycle until n*NBAR strings are out.
module sample_feeder
    import frodo_pkg::*;
#(
    parameter int NBAR  = 8,
    parameter int CNT_W = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  ctrl,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] random_string,
    output logic        en,
    output logic        busy,
    output logic        done
);

    feeder_state_t r_state;
    feeder_state_t w_state_nxt;

    logic [63:0]      r_buf;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ctrl;
    logic [15:0]      r_last;

    logic [CNT_W-1:0] w_target;
    logic             w_final;
    logic             w_legal;
    logic             w_start_ok;
    logic             w_ready;
    logic             w_take;
    logic [15:0]      w_chunk;

    // Target follows the latched level, so ctrl changes mid-run are inert.
    assign w_target = CNT_W'(ns_for(r_ctrl, NBAR));
    assign w_final  = (r_cnt == w_target - 1'b1);
    assign w_legal  = (ctrl == CTRL_640) || (ctrl == CTRL_976) ||
                      (ctrl == CTRL_1344);
    assign w_take   = w_ready & din_valid;

    // Little-endian chunk select: din[15:0] leaves first.
    always_comb begin
        w_chunk = r_buf[15:0];
        case (r_idx)
            2'd0: w_chunk = r_buf[15:0];
            2'd1: w_chunk = r_buf[31:16];
            2'd2: w_chunk = r_buf[47:32];
            2'd3: w_chunk = r_buf[63:48];
            default: w_chunk = r_buf[15:0];
        endcase
    end

    // Next-state and handshake decode; prefetch on the last chunk.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_legal) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                if (din_valid) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_final) begin
                    w_state_nxt = ST_DONE;
                end else if (r_idx == 2'd3) begin
                    w_ready = 1'b1;
                    if (!din_valid) begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Word buffer, chunk index, sample counter and held output string.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_ctrl <= '0;
            r_last <= '0;
        end else begin
            if (w_start_ok) begin
                r_ctrl <= ctrl;
                r_cnt  <= '0;
                r_idx  <= '0;
            end
            if (r_state == ST_EMIT) begin
                r_cnt  <= r_cnt + 1'b1;
                r_idx  <= r_idx + 1'b1;
                r_last <= w_chunk;
            end
            if (w_take) begin
                r_buf <= din;
                r_idx <= '0;
            end
        end
    end

    assign din_ready     = w_ready;
    assign en            = (r_state == ST_EMIT);
    assign random_string = en ? w_chunk : r_last;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);

endmodule

// File: tb/tb_sample_feeder.sv
// Self-checking bench for sample_feeder: scoreboarded runs at all
// three levels plus start/ctrl table and reset corner cases.
module tb_sample_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  ctrl;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] random_string;
    logic        en;
    logic        busy;
    logic        done;

    int n_pass;
    int n_total;
    int cyc;

    logic [15:0] q[$];

    sample_feeder #(.NBAR(8), .CNT_W(14)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .ctrl          (ctrl),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .random_string (random_string),
        .en            (en),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] c;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input longint act, input longint req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     nm, act, act, req, req);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] word_of(input int k);
        logic [15:0] b;
        b = 16'(4 * k + 1);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic run(input logic [2:0] c, input int exp_n, input int gap,
                       input int stop_after, input bit mid_start,
                       input string nm);
        int n_en, n_done, first_en, last_en, done_cyc, t0, bad, words;
        int budget;
        bit fin;
        logic [15:0] exp_s, bad_a, bad_e, last_s;
        logic [63:0] w;
        q.delete();
        n_en = 0; n_done = 0; first_en = -1; last_en = -1;
        done_cyc = -1; bad = 0; words = 0; fin = 1'b0;
        bad_a = '0; bad_e = '0; last_s = '0;
        budget = exp_n * 3 + 100;
        ctrl = c;
        start = 1'b1;
        step();
        start = 1'b0;
        ctrl = 3'($urandom);
        t0 = cyc;
        check({nm, "_load_ready"}, din_ready, 1);
        check({nm, "_load_busy"}, busy, 1);
        for (int i = 0; i < budget; i++) begin
            if (en) begin
                if (q.size() == 0) begin
                    bad++;
                end else begin
                    exp_s = q.pop_front();
                    if (random_string !== exp_s) begin
                        if (bad == 0) begin
                            bad_a = random_string;
                            bad_e = exp_s;
                        end
                        bad++;
                    end
                end
                last_s = random_string;
                n_en++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (stop_after > 0 && n_en == stop_after) begin
                fin = 1'b1;
                break;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                fin = 1'b1;
                break;
            end
            start = mid_start && (n_en == 50);
            ctrl = start ? 3'b100 : 3'($urandom);
            din_valid = ($urandom_range(99) >= gap);
            w = word_of(words);
            din = din_valid ? w : {$urandom, $urandom};
            if (din_valid && din_ready) begin
                q.push_back(w[15:0]);
                q.push_back(w[31:16]);
                q.push_back(w[47:32]);
                q.push_back(w[63:48]);
                words++;
            end
            step();
        end
        din_valid = 1'b0;
        start = 1'b0;
        check({nm, "_no_timeout"}, fin, 1);
        if (stop_after > 0) begin
            check({nm, "_strings_before_reset"}, bad, 0);
            return;
        end
        check({nm, "_en_count"}, n_en, exp_n);
        if (bad != 0)
            $display("FAIL %s_strings: %0d bad, first got 0x%0h expected 0x%0h",
                     nm, bad, bad_a, bad_e);
        n_total++;
        if (bad == 0) n_pass++;
        check({nm, "_done_pulses"}, n_done, 1);
        check({nm, "_done_latency"}, done_cyc, last_en + 1);
        check({nm, "_busy_after"}, busy, 0);
        check({nm, "_hold_string"}, random_string, last_s);
        check({nm, "_queue_empty"}, q.size(), 0);
        if (gap == 0) begin
            check({nm, "_first_en"}, first_en, t0 + 1);
            check({nm, "_unbroken"}, last_en - first_en + 1, exp_n);
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b1;
        start = 1'b0;
        ctrl = 3'b000;
        din = '0;
        din_valid = 1'b0;

        tbl[0] = '{3'b011, 1'b0};
        tbl[1] = '{3'b000, 1'b0};
        tbl[2] = '{3'b111, 1'b0};
        tbl[3] = '{3'b110, 1'b0};
        tbl[4] = '{3'b101, 1'b0};
        tbl[5] = '{3'b001, 1'b1};
        tbl[6] = '{3'b010, 1'b1};
        tbl[7] = '{3'b100, 1'b1};

        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            ctrl = 3'($urandom);
            din = {$urandom, $urandom};
            din_valid = 1'($urandom);
            step();
        end
        check("rst_din_ready", din_ready, 0);
        check("rst_en", en, 0);
        check("rst_string", random_string, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        start = 1'b0;
        din_valid = 1'b0;
        rst_n = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            ctrl = tbl[i].c;
            start = 1'b1;
            din_valid = 1'b1;
            step();
            start = 1'b0;
            din_valid = 1'b0;
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("tbl%0d_ready", i), din_ready, tbl[i].exp_busy);
            check($sformatf("tbl%0d_en", i), en, 0);
            step();
            check($sformatf("tbl%0d_en2", i), en, 0);
            rst_n = 1'b1;
            step();
            rst_n = 1'b0;
        end

        run(3'b001, 5120, 0, 0, 1'b0, "r640");
        run(3'b100, 10752, 25, 0, 1'b0, "r1344gap");

        run(3'b010, 7808, 0, 100, 1'b0, "r976cut");
        rst_n = 1'b1;
        step();
        check("midrst_en", en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", din_ready, 0);
        check("midrst_string", random_string, 0);
        rst_n = 1'b0;
        step();
        run(3'b010, 7808, 0, 0, 1'b0, "r976fresh");

        run(3'b010, 7808, 0, 0, 1'b1, "r976midstart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sample_feeder.md
# sample_feeder

Upstream driver for the Gaussian sampler in the FrodoKEM datapath. It accepts 64-bit pseudo-random words from the SHAKE/AES expander through a valid/ready handshake and slices each word into four 16-bit random strings. It presents one string per cycle to the sampler with an `en` strobe, and stops after exactly n·n̄ strings for the selected security level.

## Interface

**Parameters**
- `NBAR`, default 8: n̄, the matrix column count.
- `CNT_W`, default 14: sample counter width; must hold 1344·8 = 10752.

**Ports**
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset. Synchronous, active-high; the codebase's existing name is kept.
- `start`, in, 1: single-cycle request to begin a run.
- `ctrl`, in, 3: one-hot security level. bit0 = 640, bit1 = 976, bit2 = 1344.
- `din`, in, 64: expander word.
- `din_valid`, in, 1: `din` is valid.
- `din_ready`, out, 1: feeder accepts `din` this cycle.
- `random_string`, out, 16: string presented to the sampler.
- `en`, out, 1: `random_string` is valid this cycle; drives the sampler's `en`.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: one-cycle pulse after the last string of a run.

## Operation

**Registers**
- State: IDLE, LOAD, EMIT, DONE.
- `buf[63:0]`, chunk index `idx[1:0]`, sample counter `cnt[CNT_W-1:0]`, `target`, latched `ctrl`.

**States**
- **IDLE**
  - `start=1` with a legal one-hot `ctrl`: latch `ctrl`, set `target` = n·NBAR (5120 / 7808 / 10752), clear `cnt` and `idx`, go to LOAD.
  - `start` with an illegal `ctrl` (000, or more than one bit set) is ignored.
- **LOAD**
  - `din_ready=1`.
  - On `din_valid`: `buf <= din`, `idx <= 0`, go to EMIT.
- **EMIT**
  - `en=1`; `random_string = buf[16·idx +: 16]`. Order is little-endian: `din[15:0]` goes out first.
  - Each cycle: `cnt++`, `idx++`.
  - If `cnt == target-1`: go to DONE.
  - Else, when `idx==3`: `din_ready=1` (prefetch).
    - `din_valid=1`: reload `buf`, `idx <= 0`, stay in EMIT. No bubble.
    - `din_valid=0`: go to LOAD.
- **DONE**
  - `done=1` for exactly one cycle, then go to IDLE.

**Output rules**
- `busy` = (state ≠ IDLE).
- `en` and `random_string` are decoded from registers only. There is no combinational path from `din` or `din_valid`.
- `din_ready` is high only in LOAD, or in EMIT with `idx==3` and `cnt != target-1`.
- All targets are multiples of 4, so no partial word is ever left unused.
- `random_string` holds its last value while `en=0`.

**Boundary conditions**
- `start` while `busy` is ignored; the `ctrl` change has no effect mid-run.
- `din_valid` outside a `din_ready` cycle is ignored; words are never dropped or duplicated.
- Reset at any time, including mid-EMIT: on the next edge, state = IDLE, `cnt=0`, `idx=0`, `buf=0`.
- No abort input exists; reset is the only way to cancel a run.

## Timing

- **Reset values:** `din_ready=0`, `en=0`, `random_string=16'h0000`, `busy=0`, `done=0`.
- **Start:** `start` at edge k puts the block in LOAD in cycle k+1, with `din_ready=1`.
- **Handshake:** `din_valid & din_ready` sampled at edge j.
  - Chunk 0 is presented with `en=1` in cycle j+1.
  - The sampler's `valid` rises at edge j+2.
- **Throughput:** with `din_valid` held high, `en` stays high continuously; one string per cycle, one word per 4 cycles.
- **Run length:** a full run with no gaps lasts target + 2 cycles from `start`.
- **Completion:**
  - The last `en` cycle is m.
  - `done=1` in cycle m+1.
  - `busy=0` from cycle m+2.
  - A new `start` is accepted in cycle m+2.

## Structure

- **Shared package `frodo_pkg`:**
  - One-hot constants `CTRL_640` = 3'b001, `CTRL_976` = 3'b010, `CTRL_1344` = 3'b100.
  - `N_640`, `N_976`, `N_1344`, `NBAR`.
  - Derived sample counts `NS_640` = 5120, `NS_976` = 7808, `NS_1344` = 10752.
  - A `feeder_state_t` enum.
- **Sub-modules:** none. The chunk mux and the counter stay inline.
- **Top-level integration:** the feeder drives the sampler's `en` and `random_string` inputs directly.

## Test plan

1. **Reset values:** hold `rst_n=1` for 3 cycles with random inputs → all outputs 0, `din_ready=0`.
2. **640 run, continuous input:** `ctrl=001`, `start`; `din_valid` always high; first word `0x0004_0003_0002_0001`, later words incrementing → `random_string` = 0x0001, 0x0002, 0x0003, 0x0004, … on consecutive cycles. `en` is high for exactly 5120 unbroken cycles. `done` pulses once, 1 cycle after the last `en`.
3. **1344 run, gapped input:** `ctrl=100`, `din_valid` randomly deasserted → `en` is low during the gaps. Exactly 10752 strings, in order, with no duplicates or losses against a scoreboard.
4. **Illegal `ctrl`:** `start` with `ctrl=011`, then with `ctrl=000` → remains IDLE; `busy=0`, `din_ready=0`, `en` never high.
5. **Reset mid-run:** assert `rst_n` after 100 strings of a 976 run → next cycle `en=0`, `busy=0`. A fresh 976 run then emits exactly 7808 strings, starting from the first word supplied.
6. **`start` while busy:** pulse `start` with `ctrl=100` during a 976 run → ignored; the run still ends at 7808 strings with a single `done` pulse.
